controle_ciclo: RTL and testbench
=================================

Name: controle_ciclo

Overview:
Instruction-cycle control FSM for the processor. It consumes the slow periodic tick produced by the timer (temporizador) stage and advances one state per tick through fetch/decode/execute/memory/writeback. From the latched opcode it issues one-clock control pulses to the PC, IR, ALU, memory and register file. Everything runs in the single clkf domain; the tick is synchronized and edge-detected internally and is used only as an enable, never as a clock.

Parameters:
IW, 16, instruction width in bits
OPW, 4, opcode width; the opcode is instr_in[IW-1:IW-OPW]
CW, 16, width of the retired-instruction counter

Ports:
clkf  in  1  system clock; all flops on its rising edge
rstn  in  1  asynchronous active-low reset
tick_in  in  1  timer output; asynchronous to the FSM phase and held for many clkf cycles
run  in  1  enables execution; sampled only on steps
instr_in  in  IW  instruction word from the IR/memory path
ir_load  out  1  one-cycle pulse: load IR
pc_inc  out  1  one-cycle pulse: PC+1
pc_load  out  1  one-cycle pulse: PC <= jump target
alu_en  out  1  one-cycle pulse: ALU operate
mem_rd  out  1  one-cycle pulse: memory read
mem_wr  out  1  one-cycle pulse: memory write
reg_wr  out  1  one-cycle pulse: register-file write
halted  out  1  level, high while in PARADO
estado  out  3  current state encoding
retired  out  CW  count of completed instructions

Behaviour:
- Reset (async, rstn=0):
  - state=IDLE (0); all pulse outputs and halted = 0; retired=0; opcode register=0.
  - Sync flops (2 stages) and edge-detect flop = 0.
  - If tick_in is high at reset release, this is seen as a rising edge and yields one step.
- Step generation:
  - tick_in passes through a 2-flop synchronizer; step = sync_q & ~prev_q.
  - Exactly one step per tick_in rising edge; a tick held high never produces further steps.
  - Latency: step asserts 3 clkf edges after tick_in rises. The state register updates on the edge where step=1.
- Encoding: IDLE=0, BUSCA=1, DECOD=2, EXEC=3, MEM=4, ESCR=5, PARADO=6; 7 is unused and recovers to IDLE on the next clkf edge.
- Transitions occur only on step; with no step, state is held:
  - IDLE -> BUSCA if run=1, else stay.
  - BUSCA -> DECOD; the opcode register is loaded from instr_in on this same edge.
  - DECOD, by opcode:
    - 0 NOP and 9-E (undefined) -> retire
    - 1 LOAD and 2 STORE -> MEM
    - 3-7 ALU ops and 8 JMP -> EXEC
    - F HALT -> PARADO
  - EXEC: ALU op -> ESCR; JMP -> retire.
  - MEM: LOAD -> ESCR; STORE -> retire.
  - ESCR -> retire.
  - retire means: retired += 1 (wraps at 2^CW-1 -> 0); next state is BUSCA if run=1, else IDLE.
  - Entering PARADO also increments retired once.
  - PARADO is left only by reset; steps are ignored there.
- Pulses are registered and high for exactly one clkf cycle, starting the cycle the state register shows the new state:
  - Entering BUSCA: ir_load=1 and pc_inc=1.
  - Entering EXEC: alu_en=1 for an ALU op, or pc_load=1 for JMP.
  - Entering MEM: mem_rd=1 for LOAD, or mem_wr=1 for STORE.
  - Entering ESCR: reg_wr=1.
  - DECOD, IDLE and PARADO produce no pulses.
  - At most one of pc_load/alu_en/mem_rd/mem_wr/reg_wr is high in any cycle.
- halted is combinational from state==PARADO. estado is the state register, driven directly.
- run changes between steps have no effect until the next step.
- Reset asserted mid-instruction aborts immediately: any pulse in flight is cleared asynchronously, and no partial retire is counted.

Test Plan:
- Reset, run=1, tick_in toggling every 20 clkf cycles, instr_in opcode 0 (NOP) -> estado sequence 0,1,2,1,2…; retired increments by 1 every 2 ticks; ir_load and pc_inc each high exactly 1 cycle per BUSCA entry.
- Hold tick_in high for 200 cycles after one edge -> exactly one step; state advances once; step lands 3 clkf edges after the rising edge.
- Opcode 3 (ALU) -> states 1,2,3,5,1; alu_en pulse on EXEC entry, reg_wr pulse on ESCR entry, retired +1. Opcode 1 (LOAD) -> 1,2,4,5, with mem_rd then reg_wr. Opcode 2 (STORE) -> 1,2,4,1, with mem_wr only. Opcode 8 (JMP) -> 1,2,3,1, with pc_load only.
- Opcode F -> estado=6, halted=1, retired +1; 10 further ticks -> no change and no pulses.
- Drop run=0 while in EXEC of an ALU op -> completes ESCR, retires, goes to IDLE (0); raising run=1 -> BUSCA on the next tick.
- Preload retired to 0xFFFF via 65535 NOPs (or force) -> next retire yields 0x0000. Pulse rstn low while in MEM -> estado=0, all outputs 0 immediately, before the next clkf edge.

Source files
------------

// File: rtl/controle_ciclo.sv
// rtl/controle_ciclo.sv - instruction-cycle control FSM stepped by the synchronized timer tick
module controle_ciclo #(
  parameter int IW  = 16,
  parameter int OPW = 4,
  parameter int CW  = 16
) (
  input  logic          clkf,
  input  logic          rstn,
  input  logic          tick_in,
  input  logic          run,
  input  logic [IW-1:0] instr_in,
  output logic          ir_load,
  output logic          pc_inc,
  output logic          pc_load,
  output logic          alu_en,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic          reg_wr,
  output logic          halted,
  output logic [2:0]    estado,
  output logic [CW-1:0] retired
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BUSCA  = 3'd1,
    ST_DECOD  = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_ESCR   = 3'd5,
    ST_PARADO = 3'd6,
    ST_INVAL  = 3'd7
  } estado_t;

  localparam logic [OPW-1:0] OP_LOAD   = OPW'(1);
  localparam logic [OPW-1:0] OP_STORE  = OPW'(2);
  localparam logic [OPW-1:0] OP_ALU_LO = OPW'(3);
  localparam logic [OPW-1:0] OP_ALU_HI = OPW'(7);
  localparam logic [OPW-1:0] OP_JMP    = OPW'(8);
  localparam logic [OPW-1:0] OP_HALT   = {OPW{1'b1}};

  logic sync1_q, sync2_q, prev_q;
  logic step;

  estado_t        state_q, state_d;
  logic [OPW-1:0] opcode_q, opcode_d;
  logic [CW-1:0]  retired_q, retired_d;
  logic ir_load_q, ir_load_d, pc_inc_q, pc_inc_d, pc_load_q, pc_load_d;
  logic alu_en_q, alu_en_d, mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d;
  logic reg_wr_q, reg_wr_d;
  logic retire, count, enter;
  logic is_load, is_store, is_alu, is_jmp, is_halt;

  // Only the opcode field is decoded here; the rest belongs to the datapath.
  logic unused_instr;
  assign unused_instr = ^instr_in[IW-OPW-1:0];

  assign step     = sync2_q & ~prev_q;
  assign is_load  = (opcode_q == OP_LOAD);
  assign is_store = (opcode_q == OP_STORE);
  assign is_alu   = (opcode_q >= OP_ALU_LO) && (opcode_q <= OP_ALU_HI);
  assign is_jmp   = (opcode_q == OP_JMP);
  assign is_halt  = (opcode_q == OP_HALT);

  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    retired_d = retired_q;
    retire    = 1'b0;
    count     = 1'b0;
    ir_load_d = 1'b0;
    pc_inc_d  = 1'b0;
    pc_load_d = 1'b0;
    alu_en_d  = 1'b0;
    mem_rd_d  = 1'b0;
    mem_wr_d  = 1'b0;
    reg_wr_d  = 1'b0;

    if (state_q == ST_INVAL) begin
      state_d = ST_IDLE;
    end else if (step) begin
      case (state_q)
        ST_IDLE:  if (run) state_d = ST_BUSCA;
        ST_BUSCA: begin
          state_d  = ST_DECOD;
          opcode_d = instr_in[IW-1:IW-OPW];
        end
        ST_DECOD: begin
          if (is_load || is_store)    state_d = ST_MEM;
          else if (is_alu || is_jmp)  state_d = ST_EXEC;
          else if (is_halt) begin
            state_d = ST_PARADO;
            count   = 1'b1;
          end else                    retire  = 1'b1;
        end
        ST_EXEC:  if (is_alu) state_d = ST_ESCR; else retire = 1'b1;
        ST_MEM:   if (is_load) state_d = ST_ESCR; else retire = 1'b1;
        ST_ESCR:  retire = 1'b1;
        default:  ;
      endcase
    end

    if (retire) begin
      count   = 1'b1;
      state_d = run ? ST_BUSCA : ST_IDLE;
    end
    if (count) retired_d = retired_q + CW'(1);

    // Pulses fire on the edge the state register takes its new value.
    enter = step && (state_d != state_q);
    if (enter) begin
      case (state_d)
        ST_BUSCA: begin
          ir_load_d = 1'b1;
          pc_inc_d  = 1'b1;
        end
        ST_EXEC: begin
          alu_en_d  = is_alu;
          pc_load_d = is_jmp;
        end
        ST_MEM: begin
          mem_rd_d = is_load;
          mem_wr_d = is_store;
        end
        ST_ESCR:  reg_wr_d = 1'b1;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clkf or negedge rstn) begin
    if (!rstn) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      prev_q    <= 1'b0;
      state_q   <= ST_IDLE;
      opcode_q  <= '0;
      retired_q <= '0;
      ir_load_q <= 1'b0;
      pc_inc_q  <= 1'b0;
      pc_load_q <= 1'b0;
      alu_en_q  <= 1'b0;
      mem_rd_q  <= 1'b0;
      mem_wr_q  <= 1'b0;
      reg_wr_q  <= 1'b0;
    end else begin
      sync1_q   <= tick_in;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      retired_q <= retired_d;
      ir_load_q <= ir_load_d;
      pc_inc_q  <= pc_inc_d;
      pc_load_q <= pc_load_d;
      alu_en_q  <= alu_en_d;
      mem_rd_q  <= mem_rd_d;
      mem_wr_q  <= mem_wr_d;
      reg_wr_q  <= reg_wr_d;
    end
  end

  assign ir_load = ir_load_q;
  assign pc_inc  = pc_inc_q;
  assign pc_load = pc_load_q;
  assign alu_en  = alu_en_q;
  assign mem_rd  = mem_rd_q;
  assign mem_wr  = mem_wr_q;
  assign reg_wr  = reg_wr_q;
  assign halted  = (state_q == ST_PARADO);
  assign estado  = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_controle_ciclo.sv
// tb/tb_controle_ciclo.sv - directed bench with a plan-queue model of the instruction cycle
module tb_controle_ciclo;
  localparam int IW  = 16;
  localparam int OPW = 4;
  localparam int CW  = 16;

  logic          clkf = 1'b0;
  logic          rstn = 1'b0;
  logic          tick_in = 1'b0;
  logic          run = 1'b0;
  logic [IW-1:0] instr_in = '0;

  logic ir_load, pc_inc, pc_load, alu_en, mem_rd, mem_wr, reg_wr, halted;
  logic [2:0]    estado;
  logic [CW-1:0] retired;
  logic ir_load_w, pc_inc_w, pc_load_w, alu_en_w, mem_rd_w, mem_wr_w, reg_wr_w, halted_w;
  logic [2:0]    estado_w;
  logic [3:0]    retired_w;
  logic [6:0]    pulses;

  controle_ciclo #(.IW(IW), .OPW(OPW), .CW(CW)) dut (
    .clkf(clkf), .rstn(rstn), .tick_in(tick_in), .run(run), .instr_in(instr_in),
    .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load), .alu_en(alu_en),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .reg_wr(reg_wr), .halted(halted),
    .estado(estado), .retired(retired)
  );

  // Narrow counter copy so wrap-around is exercised within a short run.
  controle_ciclo #(.IW(IW), .OPW(OPW), .CW(4)) dut_w (
    .clkf(clkf), .rstn(rstn), .tick_in(tick_in), .run(run), .instr_in(instr_in),
    .ir_load(ir_load_w), .pc_inc(pc_inc_w), .pc_load(pc_load_w), .alu_en(alu_en_w),
    .mem_rd(mem_rd_w), .mem_wr(mem_wr_w), .reg_wr(reg_wr_w), .halted(halted_w),
    .estado(estado_w), .retired(retired_w)
  );

  always #5 clkf = ~clkf;

  assign pulses = {ir_load, pc_inc, pc_load, alu_en, mem_rd, mem_wr, reg_wr};

  localparam logic [6:0] P_IR = 7'b1000000, P_PC = 7'b0100000, P_JMP = 7'b0010000;
  localparam logic [6:0] P_ALU = 7'b0001000, P_RD = 7'b0000100, P_WR = 7'b0000010;
  localparam logic [6:0] P_REG = 7'b0000001;

  int n_checks = 0;
  int n_errors = 0;
  int m_state = 0;
  int m_retired = 0;
  int pending = 0;
  logic [3:0] m_op = '0;
  logic [6:0] e_pulse = '0;
  int plan_s[$];
  logic [6:0] plan_p[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_retired = 0; pending = 0; m_op = '0; e_pulse = '0;
    plan_s.delete(); plan_p.delete();
  endtask

  task automatic enter_busca();
    m_state = 1;
    e_pulse = P_IR | P_PC;
  endtask

  // Each instruction is a list of (state, pulse) stops after DECOD; an empty list means retire.
  task automatic model_step();
    case (m_state)
      0: if (run) enter_busca();
      1: begin
        m_op = instr_in[15:12];
        m_state = 2;
        plan_s.delete(); plan_p.delete();
        case (m_op)
          4'h1: begin plan_s = '{4, 5}; plan_p = '{P_RD, P_REG}; end
          4'h2: begin plan_s = '{4};    plan_p = '{P_WR}; end
          4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin plan_s = '{3, 5}; plan_p = '{P_ALU, P_REG}; end
          4'h8: begin plan_s = '{3};    plan_p = '{P_JMP}; end
          default: ;
        endcase
      end
      6: ;
      default: begin
        if (m_state == 2 && m_op == 4'hF) begin
          m_state = 6;
          m_retired++;
        end else if (plan_s.size() > 0) begin
          m_state = plan_s.pop_front();
          e_pulse = plan_p.pop_front();
        end else begin
          m_retired++;
          if (run) enter_busca(); else m_state = 0;
        end
      end
    endcase
  endtask

  task automatic cyc();
    @(posedge clkf);
    e_pulse = '0;
    if (!rstn) model_reset();
    else if (pending > 0) begin
      pending--;
      if (pending == 0) model_step();
    end
    #1;
    chk("estado", 32'(estado), 32'(m_state));
    chk("pulses", 32'(pulses), 32'(e_pulse));
    chk("halted", 32'(halted), 32'(m_state == 6));
    chk("retired", 32'(retired), 32'(m_retired & 32'hFFFF));
    chk("retired_w", 32'(retired_w), 32'(m_retired % 16));
  endtask

  task automatic do_step(input int half);
    tick_in = 1'b1;
    pending = 3;
    repeat (half) cyc();
    tick_in = 1'b0;
    repeat (half) cyc();
  endtask

  task automatic step_chk(input int exp_s, input string nm);
    do_step(6);
    chk(nm, 32'(estado), 32'(exp_s));
  endtask

  task automatic assert_reset();
    #2 rstn = 1'b0;
    model_reset();
    #1;
    chk("rst_estado", 32'(estado), 32'd0);
    chk("rst_pulses", 32'(pulses), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
  endtask

  task automatic release_reset();
    repeat (3) cyc();
    rstn = 1'b1;
    pending = tick_in ? 3 : 0;
  endtask

  initial begin
    run = 1'b1;
    repeat (3) cyc();
    chk("init_estado", 32'(estado), 32'd0);
    chk("init_retired", 32'(retired), 32'd0);
    rstn = 1'b1;
    repeat (4) cyc();

    // NOP stream: IDLE->BUSCA then alternate DECOD/BUSCA, one retire per two steps
    for (int i = 0; i < 37; i++) do_step(20);
    chk("nop_estado", 32'(estado), 32'd1);
    chk("nop_retired", 32'(retired), 32'd18);
    chk("nop_wrap_w", 32'(retired_w), 32'd2);

    // Held tick: one step only, landing on the third edge
    tick_in = 1'b1;
    pending = 3;
    cyc(); cyc();
    chk("hold_pre", 32'(estado), 32'd1);
    cyc();
    chk("hold_edge3", 32'(estado), 32'd2);
    repeat (200) cyc();
    chk("hold_after", 32'(estado), 32'd2);
    tick_in = 1'b0;
    repeat (6) cyc();
    step_chk(1, "nop_retire");
    chk("ret19", 32'(retired), 32'd19);

    instr_in = 16'h3000;
    step_chk(2, "alu_decod"); step_chk(3, "alu_exec");
    step_chk(5, "alu_escr");  step_chk(1, "alu_busca");
    chk("ret20", 32'(retired), 32'd20);

    instr_in = 16'h1234;
    step_chk(2, "ld_decod"); step_chk(4, "ld_mem");
    step_chk(5, "ld_escr");  step_chk(1, "ld_busca");
    instr_in = 16'h2000;
    step_chk(2, "st_decod"); step_chk(4, "st_mem"); step_chk(1, "st_busca");
    instr_in = 16'h8000;
    step_chk(2, "jmp_decod"); step_chk(3, "jmp_exec"); step_chk(1, "jmp_busca");
    instr_in = 16'h9ABC;
    step_chk(2, "und_decod"); step_chk(1, "und_busca");
    chk("ret24", 32'(retired), 32'd24);

    // run dropped mid-instruction: finish, retire, park in IDLE
    instr_in = 16'h5000;
    step_chk(2, "rd_decod"); step_chk(3, "rd_exec");
    run = 1'b0;
    step_chk(5, "rd_escr"); step_chk(0, "rd_idle");
    step_chk(0, "rd_idle_hold");
    chk("ret25", 32'(retired), 32'd25);
    run = 1'b1;
    step_chk(1, "rd_resume");

    // Reset while the MEM pulse is in flight
    instr_in = 16'h1000;
    step_chk(2, "rm_decod");
    tick_in = 1'b1;
    pending = 3;
    repeat (3) cyc();
    chk("rm_mem", 32'(estado), 32'd4);
    chk("rm_mem_rd", 32'(mem_rd), 32'd1);
    assert_reset();
    tick_in = 1'b0;
    release_reset();
    repeat (4) cyc();

    instr_in = 16'hF000;
    step_chk(1, "h_busca"); step_chk(2, "h_decod"); step_chk(6, "h_parado");
    chk("h_halted", 32'(halted), 32'd1);
    chk("h_retired", 32'(retired), 32'd1);
    for (int i = 0; i < 10; i++) step_chk(6, "h_stay");
    chk("h_retired_end", 32'(retired), 32'd1);

    // Tick already high when reset releases counts as a rising edge
    assert_reset();
    tick_in = 1'b1;
    release_reset();
    cyc(); cyc();
    chk("rel_pre", 32'(estado), 32'd0);
    cyc();
    chk("rel_step", 32'(estado), 32'd1);
    tick_in = 1'b0;
    repeat (6) cyc();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
